// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: computes WIDTH-bit A+B+cin one nibble per clock,
// least significant nibble first, through an external 4-bit CLA slice.
// The slice carry-out of each nibble becomes the carry-in of the next.
// Optional subtract mode: define NIBBLE_SERIAL_SUB_EN to add the 'sub' port.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | streaming nibbles through the slice, one per clock
// DONE  | result held on sum/carry_out until out_ready
`timescale 1ns/1ps

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic [3:0]       cla_a,
  output logic [3:0]       cla_b,
  output logic             cla_cin,
  input  logic [3:0]       cla_s,
  input  logic             cla_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
    $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            carry_r;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_shifted;
  logic [3:0]      b_nib;
  logic            cin_load;
  logic            last;

  assign last = (cnt == CW'(NIB - 1));

  // New slice sum enters at the top, so after NIB shifts nibble 0 sits at the bottom.
  if (NIB == 1) begin : g_res_one
    assign res_shifted = cla_s;
  end else begin : g_res_many
    assign res_shifted = {cla_s, res_sh[WIDTH-1:4]};
  end

`ifdef NIBBLE_SERIAL_SUB_EN
  logic sub_r;
  // Subtraction is A + ~B + 1, so the first carry-in is forced high.
  assign b_nib    = sub_r ? ~b_sh[3:0] : b_sh[3:0];
  assign cin_load = sub ? 1'b1 : op_cin;

  // Operation mode is captured alongside the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sub_r <= 1'b0;
    else if (state == IDLE && in_valid) sub_r <= sub;
  end
`else
  assign b_nib    = b_sh[3:0];
  assign cin_load = op_cin;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand shifting, carry chaining and result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      carry_r   <= 1'b0;
      carry_out <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh    <= op_a;
            b_sh    <= op_b;
            carry_r <= cin_load;
            cnt     <= '0;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 4;
          b_sh    <= b_sh >> 4;
          res_sh  <= res_shifted;
          carry_r <= cla_cout;
          cnt     <= cnt + CW'(1);
          if (last) carry_out <= cla_cout;
        end
        default: ;
      endcase
    end
  end

  // Next-state and handshake/slice outputs; slice inputs are zero outside RUN.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    cla_a     = 4'h0;
    cla_b     = 4'h0;
    cla_cin   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        cla_a   = a_sh[3:0];
        cla_b   = b_nib;
        cla_cin = carry_r;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sum = res_sh;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (WIDTH=16) with a behavioural
// 4-bit adder slice attached to the cla_* ports.
`timescale 1ns/1ps

module tb_nibble_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a, op_b;
  logic        op_cin;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic        sub;
`endif
  logic [3:0]  cla_a, cla_b, cla_s;
  logic        cla_cin, cla_cout;
  logic        out_valid, out_ready;
  logic [15:0] sum;
  logic        carry_out, busy;
  logic [4:0]  slice;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Behavioural adder slice standing in for the external CLA.
  assign slice    = {1'b0, cla_a} + {1'b0, cla_b} + {4'b0, cla_cin};
  assign cla_s    = slice[3:0];
  assign cla_cout = slice[4];

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
`ifdef NIBBLE_SERIAL_SUB_EN
    .sub(sub),
`endif
    .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
    .cla_s(cla_s), .cla_cout(cla_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full operation: accept, check each RUN cycle, check result, complete handshake.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [15:0] exp_cla_a,
                       input logic [3:0] exp_cin_seq, input logic [15:0] exp_sum,
                       input logic exp_cout);
    chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    op_a = a; op_b = b; op_cin = cin; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_cla_a"}, 32'(cla_a), 32'(exp_cla_a[4*k +: 4]));
      chk({tag, "_cla_cin"}, 32'(cla_cin), 32'(exp_cin_seq[k]));
      chk({tag, "_run_valid"}, {30'd0, out_valid, in_ready}, 32'd0);
      step();
    end
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    chk({tag, "_carry_out"}, 32'(carry_out), 32'(exp_cout));
    chk({tag, "_done_slice"}, {23'd0, cla_a, cla_b, cla_cin}, 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_back_idle"}, {29'd0, out_valid, in_ready, busy}, 32'b010);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_cin = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
    sub = 1'b0;
`endif
    step();
    chk("rst_ctl", {29'd0, in_ready, out_valid, busy}, 32'b100);
    chk("rst_sum", {15'd0, carry_out, sum}, 32'd0);
    chk("rst_slice", {23'd0, cla_a, cla_b, cla_cin}, 32'd0);
    rst_n = 1'b1;
    step();

    do_op("t1234", 16'h1234, 16'h4321, 1'b0, 16'h1234, 4'b0000, 16'h5555, 1'b0);
    do_op("tffff", 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 4'b1110, 16'h0000, 1'b1);
    do_op("tcin", 16'h0000, 16'h0000, 1'b1, 16'h0000, 4'b0001, 16'h0001, 1'b0);

    // Backpressure with operands offered during RUN and DONE.
    op_a = 16'h0F0F; op_b = 16'h0101; op_cin = 1'b0; in_valid = 1'b1;
    step();
    op_a = 16'hAAAA; op_b = 16'h5555;
    for (int k = 0; k < 4; k++) begin
      chk("bp_run_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", {30'd0, out_valid, in_ready}, 32'b10);
      chk("bp_hold_sum", {15'd0, carry_out, sum}, {15'd0, 1'b0, 16'h1010});
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release", {29'd0, out_valid, in_ready, busy}, 32'b010);
    step();
    in_valid = 1'b0;
    chk("bp_second_accept", {30'd0, busy, in_ready}, 32'b10);
    for (int k = 0; k < 4; k++) step();
    chk("bp_second_valid", 32'(out_valid), 32'd1);
    chk("bp_second_sum", {15'd0, carry_out, sum}, {15'd0, 1'b0, 16'hFFFF});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset in the second RUN cycle.
    op_a = 16'h1234; op_b = 16'h1111; op_cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("rr_mid_run", {30'd0, busy, out_valid}, 32'b10);
    rst_n = 1'b0;
    #1;
    chk("rr_ctl", {29'd0, in_ready, out_valid, busy}, 32'b100);
    chk("rr_sum", {15'd0, carry_out, sum}, 32'd0);
    chk("rr_slice", {23'd0, cla_a, cla_b, cla_cin}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_no_valid", 32'(out_valid), 32'd0);
      step();
    end
    do_op("t00ff", 16'h00FF, 16'h0001, 1'b0, 16'h00FF, 4'b0110, 16'h0100, 1'b0);

`ifdef NIBBLE_SERIAL_SUB_EN
    sub = 1'b1;
    do_op("sub57", 16'h0005, 16'h0007, 1'b0, 16'h0005, 4'b0001, 16'hFFFE, 1'b0);
    do_op("sub75", 16'h0007, 16'h0005, 1'b0, 16'h0007, 4'b1111, 16'h0002, 1'b1);
    sub = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
